// File: rtl/cu_graph_result_write_control.sv
// cu_graph_result_write_control
// Packs a stream of 64-bit result words into 128-byte lines and issues one
// WRITE_NA command per line, tracking outstanding writes and response errors.
// Optional feature macro: CU_RESULT_FLUSH_TIMEOUT_EN -- when defined, a partial
// line is flushed after TIMEOUT_CYCLES idle cycles in FILL.

package cu_result_pkg;
  typedef enum logic [1:0] {
    RESP_DONE   = 2'd0,
    RESP_FAILED = 2'd1,
    RESP_AERROR = 2'd2,
    RESP_NRES   = 2'd3
  } response_t;

  typedef enum logic [1:0] {
    CMD_NONE   = 2'd0,
    WRITE_NA   = 2'd1,
    READ_CL_NA = 2'd2
  } command_t;

  typedef struct packed {
    logic        valid;
    logic [63:0] result_array_base;
  } WEDInterface;

  typedef struct packed {
    logic empty;
    logic alfull;
    logic full;
  } BufferStatus;

  typedef struct packed {
    logic      valid;
    logic [7:0] tag;
    response_t response;
  } ResponseBufferLine;

  typedef struct packed {
    logic        valid;
    command_t    command;
    logic [63:0] address;
    logic [7:0]  size;
    logic [7:0]  tag;
  } CommandBufferLine;

  typedef struct packed {
    logic         valid;
    logic [511:0] data;
  } ReadWriteDataLine;
endpackage

module cu_graph_result_write_control #(
  parameter int OUT_MAX        = 8,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                             clock,
  input  logic                             rstn,
  input  logic                             enabled,
  input  cu_result_pkg::WEDInterface       wed_request_in,
  input  logic                             result_valid,
  input  logic [63:0]                      result_data,
  output logic                             result_ready,
  input  logic                             result_last,
  input  cu_result_pkg::BufferStatus       write_buffer_status,
  input  cu_result_pkg::ResponseBufferLine write_response_in,
  output cu_result_pkg::CommandBufferLine  write_command_out,
  output cu_result_pkg::ReadWriteDataLine  write_data_0_out,
  output cu_result_pkg::ReadWriteDataLine  write_data_1_out,
  output logic                             done_out,
  output logic [15:0]                      error_count_out
);

  typedef enum logic [2:0] {IDLE, FILL, ISSUE, DRAIN, DONE} state_t;

  localparam logic [6:0] OUT_MAX_W = 7'(OUT_MAX);

  state_t       state_reg;
  logic [63:0]  buf_reg [16];
  logic [4:0]   word_count_reg;
  logic [56:0]  line_index_reg;
  logic [63:0]  base_reg;
  logic [6:0]   outstanding_reg;
  logic [15:0]  error_count_reg;
  logic         flush_last_reg;
  logic         done_reg;

  logic         cmd_valid_reg;
  logic [63:0]  cmd_address_reg;
  logic [7:0]   cmd_size_reg;
  logic [7:0]   cmd_tag_reg;
  logic         data_valid_reg;
  logic [511:0] data_0_reg;
  logic [511:0] data_1_reg;

  logic [1023:0] line_flat;
  logic          accept;
  logic          issue_ok;
  logic          resp_take;
  logic          timeout_hit;

  // Status and tag fields that this block does not act on
  logic unused_bits;
  assign unused_bits = ^{write_buffer_status.empty, write_buffer_status.full,
                         write_response_in.tag};

  // Flatten the word buffer so word k lands at byte offset 8*k
  for (genvar gi = 0; gi < 16; gi++) begin : g_flat
    assign line_flat[gi*64 +: 64] = buf_reg[gi];
  end

  assign result_ready = (state_reg == FILL) && enabled && wed_request_in.valid;
  assign accept       = result_valid && result_ready;
  assign issue_ok     = (state_reg == ISSUE) && enabled &&
                        !write_buffer_status.alfull &&
                        (outstanding_reg < OUT_MAX_W);
  // A response with nothing outstanding is ignored entirely
  assign resp_take    = write_response_in.valid && (outstanding_reg != 7'd0);

`ifdef CU_RESULT_FLUSH_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] idle_count_reg;

  assign timeout_hit = (state_reg == FILL) && enabled && !accept &&
                       (word_count_reg != 5'd0) &&
                       (idle_count_reg == TW'(TIMEOUT_CYCLES - 1));

  // Count consecutive idle cycles while a partial line waits in FILL
  always_ff @(posedge clock) begin
    if (!rstn) begin
      idle_count_reg <= '0;
    end else if (state_reg != FILL || accept || timeout_hit ||
                 word_count_reg == 5'd0) begin
      idle_count_reg <= '0;
    end else if (enabled) begin
      idle_count_reg <= idle_count_reg + 1'b1;
    end
  end
`else
  localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
  assign timeout_hit = 1'b0;
`endif

  // Line buffer: capture accepted words, clear once the line is issued
  always_ff @(posedge clock) begin
    if (!rstn || issue_ok) begin
      for (int i = 0; i < 16; i++) buf_reg[i] <= '0;
    end else if (accept) begin
      buf_reg[word_count_reg[3:0]] <= result_data;
    end
  end

  // Control FSM with registered command/data outputs and counters
  always_ff @(posedge clock) begin
    if (!rstn) begin
      state_reg       <= IDLE;
      word_count_reg  <= '0;
      line_index_reg  <= '0;
      base_reg        <= '0;
      outstanding_reg <= '0;
      error_count_reg <= '0;
      flush_last_reg  <= 1'b0;
      done_reg        <= 1'b0;
      cmd_valid_reg   <= 1'b0;
      cmd_address_reg <= '0;
      cmd_size_reg    <= '0;
      cmd_tag_reg     <= '0;
      data_valid_reg  <= 1'b0;
      data_0_reg      <= '0;
      data_1_reg      <= '0;
    end else begin
      cmd_valid_reg  <= 1'b0;
      data_valid_reg <= 1'b0;

      // Simultaneous issue and response cancel out
      if (issue_ok && !resp_take)
        outstanding_reg <= outstanding_reg + 7'd1;
      else if (!issue_ok && resp_take)
        outstanding_reg <= outstanding_reg - 7'd1;

      if (resp_take && write_response_in.response != cu_result_pkg::RESP_DONE &&
          error_count_reg != 16'hFFFF)
        error_count_reg <= error_count_reg + 16'd1;

      case (state_reg)
        IDLE: begin
          if (wed_request_in.valid && enabled) begin
            base_reg  <= wed_request_in.result_array_base;
            state_reg <= FILL;
          end
        end
        FILL: begin
          if (accept) begin
            word_count_reg <= word_count_reg + 5'd1;
            if (word_count_reg == 5'd15 || result_last) begin
              flush_last_reg <= result_last;
              state_reg      <= ISSUE;
            end
          end else if (timeout_hit) begin
            flush_last_reg <= 1'b0;
            state_reg      <= ISSUE;
          end
        end
        ISSUE: begin
          if (issue_ok) begin
            cmd_valid_reg   <= 1'b1;
            cmd_address_reg <= base_reg + {line_index_reg, 7'b0};
            cmd_size_reg    <= {word_count_reg, 3'b000};
            cmd_tag_reg     <= line_index_reg[7:0];
            data_valid_reg  <= 1'b1;
            data_0_reg      <= line_flat[511:0];
            data_1_reg      <= line_flat[1023:512];
            line_index_reg  <= line_index_reg + 57'd1;
            word_count_reg  <= '0;
            state_reg       <= flush_last_reg ? DRAIN : FILL;
          end
        end
        DRAIN: begin
          if (outstanding_reg == 7'd0) begin
            done_reg  <= 1'b1;
            state_reg <= DONE;
          end
        end
        DONE: begin
          done_reg <= 1'b1;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign write_command_out.valid   = cmd_valid_reg;
  assign write_command_out.command = cmd_valid_reg ? cu_result_pkg::WRITE_NA
                                                   : cu_result_pkg::CMD_NONE;
  assign write_command_out.address = cmd_address_reg;
  assign write_command_out.size    = cmd_size_reg;
  assign write_command_out.tag     = cmd_tag_reg;
  assign write_data_0_out.valid    = data_valid_reg;
  assign write_data_0_out.data     = data_0_reg;
  assign write_data_1_out.valid    = data_valid_reg;
  assign write_data_1_out.data     = data_1_reg;
  assign done_out                  = done_reg;
  assign error_count_out           = error_count_reg;

endmodule

// File: tb/tb_cu_graph_result_write_control.sv
// Directed testbench for cu_graph_result_write_control (OUT_MAX=2).
// Honors CU_RESULT_FLUSH_TIMEOUT_EN to choose the timeout expectation.

module tb_cu_graph_result_write_control;
  import cu_result_pkg::*;

  logic              clock = 1'b0;
  logic              rstn;
  logic              enabled;
  WEDInterface       wed_request_in;
  logic              result_valid;
  logic [63:0]       result_data;
  logic              result_ready;
  logic              result_last;
  BufferStatus       write_buffer_status;
  ResponseBufferLine write_response_in;
  CommandBufferLine  write_command_out;
  ReadWriteDataLine  write_data_0_out;
  ReadWriteDataLine  write_data_1_out;
  logic              done_out;
  logic [15:0]       error_count_out;

  typedef struct {
    logic [63:0]  addr;
    logic [7:0]   size;
    logic [7:0]   tag;
    command_t     cmd;
    logic         d0v;
    logic         d1v;
    logic [511:0] d0;
    logic [511:0] d1;
    int           cyc;
  } cmd_rec_t;

  cmd_rec_t cmd_q[$];
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit sender_done;

  always #5 clock = ~clock;

  cu_graph_result_write_control #(
    .OUT_MAX(2),
    .TIMEOUT_CYCLES(256)
  ) dut (
    .clock(clock),
    .rstn(rstn),
    .enabled(enabled),
    .wed_request_in(wed_request_in),
    .result_valid(result_valid),
    .result_data(result_data),
    .result_ready(result_ready),
    .result_last(result_last),
    .write_buffer_status(write_buffer_status),
    .write_response_in(write_response_in),
    .write_command_out(write_command_out),
    .write_data_0_out(write_data_0_out),
    .write_data_1_out(write_data_1_out),
    .done_out(done_out),
    .error_count_out(error_count_out)
  );

  always @(posedge clock) cyc++;

  // Record every cycle on which a command is presented
  always @(negedge clock) begin
    if (write_command_out.valid === 1'b1) begin
      cmd_rec_t r;
      r.addr = write_command_out.address;
      r.size = write_command_out.size;
      r.tag  = write_command_out.tag;
      r.cmd  = write_command_out.command;
      r.d0v  = write_data_0_out.valid;
      r.d1v  = write_data_1_out.valid;
      r.d0   = write_data_0_out.data;
      r.d1   = write_data_1_out.data;
      r.cyc  = cyc;
      cmd_q.push_back(r);
      $display("cmd: addr=%h size=%0d tag=%0d cyc=%0d", r.addr, r.size, r.tag, r.cyc);
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    enabled = 1'b0;
    result_valid = 1'b0;
    result_last = 1'b0;
    result_data = '0;
    write_buffer_status = '0;
    write_response_in = '0;
    wed_request_in = '0;
    idle(2);
    rstn = 1'b1;
    cmd_q.delete();
    wed_request_in.valid = 1'b1;
    wed_request_in.result_array_base = 64'h1000;
    enabled = 1'b1;
    idle(1);
  endtask

  task automatic send_word(input logic [63:0] d, input logic last);
    bit ok = 0;
    result_valid = 1'b1;
    result_data = d;
    result_last = last;
    for (int i = 0; i < 400 && !ok; i++) begin
      @(negedge clock);
      if (result_ready === 1'b1) ok = 1;
      @(posedge clock);
      #1;
    end
    result_valid = 1'b0;
    result_last = 1'b0;
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL send_word: word %h not accepted, got ready=%b required 1", d, result_ready);
    end
  endtask

  task automatic send_resp(input response_t code);
    write_response_in.valid = 1'b1;
    write_response_in.tag = 8'd0;
    write_response_in.response = code;
    @(posedge clock);
    #1;
    write_response_in.valid = 1'b0;
    $display("resp: code=%0d", code);
  endtask

  task automatic wait_cmds(input int n, input int bound);
    for (int i = 0; i < bound && cmd_q.size() < n; i++) @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    enabled = 1'b1;
    wed_request_in.valid = 1'b1;
    wed_request_in.result_array_base = 64'h1000;
    result_valid = 1'b1;
    result_last = 1'b0;
    result_data = 64'h55;
    write_buffer_status = '0;
    write_response_in = '0;
    idle(3);
    @(negedge clock);
    checks++; if (result_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b required 0", result_ready); end
    checks++; if (done_out !== 1'b0) begin errors++; $display("FAIL reset_done: got %b required 0", done_out); end
    checks++; if (write_command_out.valid !== 1'b0) begin errors++; $display("FAIL reset_cmd_valid: got %b required 0", write_command_out.valid); end
    checks++; if (write_data_0_out.valid !== 1'b0 || write_data_1_out.valid !== 1'b0) begin errors++; $display("FAIL reset_data_valid: got %b%b required 00", write_data_0_out.valid, write_data_1_out.valid); end
    checks++; if (error_count_out !== 16'd0) begin errors++; $display("FAIL reset_errcnt: got %0d required 0", error_count_out); end
    $display("test_reset done");
  endtask

  task automatic test_full_line();
    cmd_rec_t r;
    do_reset();
    for (int w = 1; w <= 16; w++) send_word(64'(w), 1'b0);
    wait_cmds(1, 20);
    idle(10);
    checks++; if (cmd_q.size() !== 1) begin errors++; $display("FAIL full_count: got %0d required 1", cmd_q.size()); end
    if (cmd_q.size() >= 1) begin
      r = cmd_q[0];
      checks++; if (r.addr !== 64'h1000) begin errors++; $display("FAIL full_addr: got %h required 1000", r.addr); end
      checks++; if (r.size !== 8'd128) begin errors++; $display("FAIL full_size: got %0d required 128", r.size); end
      checks++; if (r.tag !== 8'd0) begin errors++; $display("FAIL full_tag: got %0d required 0", r.tag); end
      checks++; if (r.cmd !== WRITE_NA) begin errors++; $display("FAIL full_cmd: got %0d required %0d", r.cmd, WRITE_NA); end
      checks++; if (r.d0v !== 1'b1 || r.d1v !== 1'b1) begin errors++; $display("FAIL full_dvalid: got %b%b required 11", r.d0v, r.d1v); end
      checks++; if (r.d0[63:0] !== 64'd1) begin errors++; $display("FAIL full_d0w0: got %0d required 1", r.d0[63:0]); end
      checks++; if (r.d0[511:448] !== 64'd8) begin errors++; $display("FAIL full_d0w7: got %0d required 8", r.d0[511:448]); end
      checks++; if (r.d1[63:0] !== 64'd9) begin errors++; $display("FAIL full_d1w0: got %0d required 9", r.d1[63:0]); end
      checks++; if (r.d1[511:448] !== 64'd16) begin errors++; $display("FAIL full_d1w7: got %0d required 16", r.d1[511:448]); end
    end
    $display("test_full_line done");
  endtask

  task automatic test_last_flush();
    cmd_rec_t r;
    do_reset();
    for (int w = 101; w <= 120; w++) send_word(64'(w), w == 120);
    wait_cmds(2, 40);
    idle(5);
    checks++; if (cmd_q.size() !== 2) begin errors++; $display("FAIL last_count: got %0d required 2", cmd_q.size()); end
    if (cmd_q.size() >= 2) begin
      r = cmd_q[0];
      checks++; if (r.addr !== 64'h1000 || r.size !== 8'd128) begin errors++; $display("FAIL last_cmd0: got %h/%0d required 1000/128", r.addr, r.size); end
      r = cmd_q[1];
      checks++; if (r.addr !== 64'h1080 || r.size !== 8'd32) begin errors++; $display("FAIL last_cmd1: got %h/%0d required 1080/32", r.addr, r.size); end
      checks++; if (r.tag !== 8'd1) begin errors++; $display("FAIL last_tag1: got %0d required 1", r.tag); end
      checks++; if (r.d0[63:0] !== 64'd117 || r.d0[255:192] !== 64'd120) begin errors++; $display("FAIL last_data: got %0d,%0d required 117,120", r.d0[63:0], r.d0[255:192]); end
      checks++; if (r.d0[511:256] !== '0 || r.d1 !== '0) begin errors++; $display("FAIL last_zero_pad: got nonzero unused bytes required zero"); end
    end
    checks++; if (done_out !== 1'b0) begin errors++; $display("FAIL last_done_early: got %b required 0", done_out); end
    send_resp(RESP_DONE);
    idle(3);
    checks++; if (done_out !== 1'b0) begin errors++; $display("FAIL last_done_one_resp: got %b required 0", done_out); end
    send_resp(RESP_DONE);
    idle(3);
    checks++; if (done_out !== 1'b1) begin errors++; $display("FAIL last_done: got %b required 1", done_out); end
    idle(10);
    checks++; if (done_out !== 1'b1) begin errors++; $display("FAIL last_done_hold: got %b required 1", done_out); end
    checks++; if (error_count_out !== 16'd0) begin errors++; $display("FAIL last_errcnt: got %0d required 0", error_count_out); end
    $display("test_last_flush done");
  endtask

  task automatic test_outstanding();
    do_reset();
    sender_done = 0;
    fork
      begin
        for (int w = 1; w <= 64; w++) send_word(64'(w), 1'b0);
        sender_done = 1;
      end
    join_none
    idle(100);
    checks++; if (cmd_q.size() !== 2) begin errors++; $display("FAIL out_stall2: got %0d required 2", cmd_q.size()); end
    send_resp(RESP_DONE);
    idle(30);
    checks++; if (cmd_q.size() !== 3) begin errors++; $display("FAIL out_release3: got %0d required 3", cmd_q.size()); end
    send_resp(RESP_DONE);
    for (int i = 0; i < 200 && !sender_done; i++) @(posedge clock);
    idle(10);
    checks++; if (sender_done !== 1'b1) begin errors++; $display("FAIL out_sender: got %b required 1", sender_done); end
    checks++; if (cmd_q.size() !== 4) begin errors++; $display("FAIL out_release4: got %0d required 4", cmd_q.size()); end
    if (cmd_q.size() >= 4) begin
      checks++; if (cmd_q[2].addr !== 64'h1100 || cmd_q[3].addr !== 64'h1180) begin errors++; $display("FAIL out_addr: got %h,%h required 1100,1180", cmd_q[2].addr, cmd_q[3].addr); end
      checks++; if (cmd_q[3].tag !== 8'd3) begin errors++; $display("FAIL out_tag3: got %0d required 3", cmd_q[3].tag); end
    end
    $display("test_outstanding done");
  endtask

  task automatic test_alfull();
    do_reset();
    write_buffer_status.alfull = 1'b1;
    for (int w = 1; w <= 16; w++) send_word(64'(w + 200), 1'b0);
    idle(10);
    checks++; if (cmd_q.size() !== 0) begin errors++; $display("FAIL alfull_hold: got %0d commands required 0", cmd_q.size()); end
    write_buffer_status.alfull = 1'b0;
    @(negedge clock);
    checks++; if (write_command_out.valid !== 1'b0) begin errors++; $display("FAIL alfull_same_cycle: got %b required 0", write_command_out.valid); end
    @(negedge clock);
    checks++; if (write_command_out.valid !== 1'b1) begin errors++; $display("FAIL alfull_next_cycle: got %b required 1", write_command_out.valid); end
    idle(5);
    checks++; if (cmd_q.size() !== 1) begin errors++; $display("FAIL alfull_count: got %0d required 1", cmd_q.size()); end
    $display("test_alfull done");
  endtask

  task automatic test_error();
    do_reset();
    for (int w = 1; w <= 16; w++) send_word(64'(w), 1'b0);
    wait_cmds(1, 20);
    send_resp(RESP_FAILED);
    idle(1);
    checks++; if (error_count_out !== 16'd1) begin errors++; $display("FAIL err_count: got %0d required 1", error_count_out); end
    send_word(64'd7, 1'b1);
    wait_cmds(2, 20);
    checks++; if (cmd_q.size() !== 2) begin errors++; $display("FAIL err_flush_count: got %0d required 2", cmd_q.size()); end
    if (cmd_q.size() >= 2) begin
      checks++; if (cmd_q[1].size !== 8'd8 || cmd_q[1].addr !== 64'h1080) begin errors++; $display("FAIL err_flush_cmd: got %h/%0d required 1080/8", cmd_q[1].addr, cmd_q[1].size); end
    end
    send_resp(RESP_DONE);
    idle(3);
    checks++; if (done_out !== 1'b1) begin errors++; $display("FAIL err_done: got %b required 1", done_out); end
    checks++; if (error_count_out !== 16'd1) begin errors++; $display("FAIL err_count_after_done: got %0d required 1", error_count_out); end
    send_resp(RESP_FAILED);
    idle(2);
    checks++; if (error_count_out !== 16'd1) begin errors++; $display("FAIL err_stray_resp: got %0d required 1", error_count_out); end
    checks++; if (done_out !== 1'b1) begin errors++; $display("FAIL err_done_hold: got %b required 1", done_out); end
    $display("test_error done");
  endtask

  task automatic test_timeout();
    int c0;
    do_reset();
    send_word(64'hA, 1'b0);
    send_word(64'hB, 1'b0);
    send_word(64'hC, 1'b0);
    c0 = cyc;
    wait_cmds(1, 300);
`ifdef CU_RESULT_FLUSH_TIMEOUT_EN
    checks++; if (cmd_q.size() !== 1) begin errors++; $display("FAIL timeout_count: got %0d required 1", cmd_q.size()); end
    if (cmd_q.size() >= 1) begin
      checks++; if (cmd_q[0].size !== 8'd24) begin errors++; $display("FAIL timeout_size: got %0d required 24", cmd_q[0].size); end
      checks++; if (cmd_q[0].addr !== 64'h1000) begin errors++; $display("FAIL timeout_addr: got %h required 1000", cmd_q[0].addr); end
      checks++; if (cmd_q[0].d0[191:128] !== 64'hC) begin errors++; $display("FAIL timeout_data: got %h required c", cmd_q[0].d0[191:128]); end
      checks++; if (cmd_q[0].cyc - c0 !== 257) begin errors++; $display("FAIL timeout_latency: got %0d required 257", cmd_q[0].cyc - c0); end
    end
    send_word(64'hD, 1'b0);
    checks++; if (result_ready !== 1'b1) begin errors++; $display("FAIL timeout_back_to_fill: got %b required 1", result_ready); end
`else
    checks++; if (cmd_q.size() !== 0) begin errors++; $display("FAIL timeout_disabled: got %0d commands required 0", cmd_q.size()); end
    checks++; if (result_ready !== 1'b1) begin errors++; $display("FAIL timeout_still_fill: got %b required 1", result_ready); end
`endif
    $display("test_timeout done");
  endtask

  initial begin
    test_reset();
    test_full_line();
    test_last_flush();
    test_outstanding();
    test_alfull();
    test_error();
    test_timeout();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
